// File: rtl/cam_img_seq.sv
// rtl/cam_img_seq.sv - command sequencer driving cam_top load and search
// Loads streamed images into CAM slots and scores query images per slot.
module cam_img_seq #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 24,
  parameter int NUM_IMG   = 2,
  parameter int MATCH_LAT = 1,
  localparam int SLOT_W   = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [SLOT_W-1:0]         cmd_slot,
  input  logic [ADDR_W-1:0]         cmd_len,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [DATA_W-1:0]         pix_data,
  output logic [NUM_IMG-1:0]        cam_we,
  output logic                      cam_match_en,
  output logic [ADDR_W-1:0]         cam_addr,
  output logic [DATA_W-1:0]         cam_din,
  input  logic [NUM_IMG-1:0]        cam_match,
  output logic                      done,
  output logic                      err,
  output logic [SLOT_W-1:0]         res_best,
  output logic                      res_full,
  output logic [NUM_IMG*ADDR_W-1:0] res_hits
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEARCH, S_DRAIN, S_REPORT} state_t;

  // Bits of the match pipeline still pending after the one retiring this cycle.
  localparam logic [MATCH_LAT-1:0] LOW_MASK = MATCH_LAT'((64'd1 << (MATCH_LAT - 1)) - 64'd1);

  state_t                          state_q, state_d;
  logic                            search_q, search_d;
  logic                            err_q, err_d;
  logic                            rdy_q, rdy_d;
  logic [SLOT_W-1:0]               slot_q, slot_d;
  logic [ADDR_W-1:0]               len_q, len_d;
  logic [ADDR_W-1:0]               idx_q, idx_d;
  logic [NUM_IMG-1:0][ADDR_W-1:0]  hits_q, hits_d;
  logic [MATCH_LAT-1:0]            sr_q, sr_d;
  logic [NUM_IMG-1:0]              we_q, we_d;
  logic                            men_q, men_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [DATA_W-1:0]               din_q, din_d;

  logic              accept, illegal, hs, count;
  logic [ADDR_W-1:0] idx_inc;
  logic [SLOT_W-1:0] best;

  assign accept  = cmd_valid && rdy_q;
  assign illegal = cmd_op[1] || ((cmd_op == 2'b00) && (int'(cmd_slot) >= NUM_IMG));
  assign hs      = pix_valid && pix_ready;
  assign idx_inc = idx_q + 1'b1;
  assign count   = sr_q[MATCH_LAT-1] && ((state_q == S_SEARCH) || (state_q == S_DRAIN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      search_q <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      slot_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      hits_q   <= '0;
      sr_q     <= '0;
      we_q     <= '0;
      men_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      search_q <= search_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      slot_q   <= slot_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      hits_q   <= hits_d;
      sr_q     <= sr_d;
      we_q     <= we_d;
      men_q    <= men_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (illegal || (cmd_len == '0)) state_d = S_REPORT;
          else if (cmd_op == 2'b00)       state_d = S_LOAD;
          else                            state_d = S_SEARCH;
        end
      end
      S_LOAD:   if (hs && (idx_inc == len_q)) state_d = S_REPORT;
      S_SEARCH: if (hs && (idx_inc == len_q)) state_d = S_DRAIN;
      S_DRAIN:  if (!men_q && ((sr_q & LOW_MASK) == '0)) state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    search_d = search_q;
    err_d    = err_q;
    slot_d   = slot_q;
    len_d    = len_q;
    idx_d    = idx_q;
    we_d     = '0;
    men_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    rdy_d    = (state_d == S_IDLE);
    sr_d[0]  = men_q;
    for (int i = 1; i < MATCH_LAT; i++) sr_d[i] = sr_q[i-1];
    for (int i = 0; i < NUM_IMG; i++)
      hits_d[i] = hits_q[i] + ADDR_W'(count && cam_match[i] && (hits_q[i] != '1));

    if (accept) begin
      search_d = (cmd_op == 2'b01);
      err_d    = illegal;
      slot_d   = cmd_slot;
      len_d    = cmd_len;
      idx_d    = '0;
      hits_d   = '0;
      sr_d     = '0;
    end
    if ((state_q == S_LOAD) && hs) begin
      we_d   = NUM_IMG'(1) << slot_q;
      addr_d = idx_inc;
      din_d  = pix_data;
      idx_d  = idx_inc;
    end
    if ((state_q == S_SEARCH) && hs) begin
      men_d  = 1'b1;
      addr_d = '0;
      din_d  = pix_data;
      idx_d  = idx_inc;
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best = '0;
    for (int i = 1; i < NUM_IMG; i++)
      if (hits_q[i] > hits_q[best]) best = SLOT_W'(i);
  end

  always_comb begin
    cmd_ready = rdy_q;
    pix_ready = ((state_q == S_LOAD) || (state_q == S_SEARCH)) && (idx_q < len_q);
    done      = (state_q == S_REPORT);
    err       = (state_q == S_REPORT) && err_q;
    res_best  = search_q ? best : '0;
    res_full  = search_q && (len_q != '0) && (hits_q[best] == len_q);
    res_hits  = hits_q;
  end

  assign cam_we       = we_q;
  assign cam_match_en = men_q;
  assign cam_addr     = addr_q;
  assign cam_din      = din_q;

endmodule
